cpu_core_pipe: RTL
==================

Name: cpu_core_pipe

Overview:
Parametrised 2-stage (fetch/execute) pipelined accumulator CPU core, the successor of the fixed 4-bit CPU top. Data width and address width are configurable. Adds a fetch ready handshake, branch squash, a page register for wide jump targets, and an output-valid strobe. Sits between program memory (address/mem_rdata) and board I/O (in_port/out_port).

Parameters:
DATA_W, 4, width of A, B, in_port, out_port and the instruction immediate
ADDR_W, 12, program counter and address width; must be greater than DATA_W
PAGE_W (localparam), ADDR_W-DATA_W, page register width
INSTR_W (localparam), 4+DATA_W, instruction width: [INSTR_W-1:DATA_W]=opcode, [DATA_W-1:0]=imm

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low; low clears all state immediately
mem_rdata  input  INSTR_W  instruction at address
mem_ready  input  1  mem_rdata valid this cycle
in_port  input  DATA_W  input port, sampled by IN in execute
address  output  ADDR_W  fetch address = PC
a_reg_out  output  DATA_W  register A
b_reg_out  output  DATA_W  register B
out_port  output  DATA_W  output register
out_valid  output  1  one-cycle pulse when an OUT executes

Behaviour:
- Reset (reset low): PC=0, IR=NOP with ir_valid=0, A=B=out_port=0, cflag=0, page=0, out_valid=0. Applies mid-instruction, no partial update survives.
- Fetch: if mem_ready=1 on an edge, IR<=mem_rdata, ir_valid<=1, PC<=PC+1 (mod 2^ADDR_W, 0xFFF->0x000). If mem_ready=0: PC holds, ir_valid<=0 (bubble).
- Execute: IR decoded when ir_valid=1; all results commit on the same edge as the next fetch. Latency 1 cycle after fetch; no data hazards since registers are read/written only in execute.
- Opcodes: 0 ADD A,imm; 1 MOV A,B; 2 IN A; 3 MOV A,imm; 4 MOV B,A; 5 ADD B,imm; 6 IN B; 7 MOV B,imm; 8 ADD A,B; 9 OUT B; A NOP; B OUT imm; C LDPG imm; D NOP; E JNC imm; F JMP imm.
- ADD: DATA_W-bit wrap sum; cflag<=carry-out. All other executed ops, including jumps, clear cflag. NOP and bubbles leave cflag unchanged.
- LDPG: page<=((page<<DATA_W)|imm) truncated to PAGE_W.
- Jump target={page,imm}. JMP always taken; JNC taken iff cflag=0 at execute.
- Taken jump: PC<=target on that edge, overriding increment and mem_ready. The instruction fetched on the same edge is squashed (ir_valid<=0). Penalty 1 cycle.
- OUT: out_port<=B or imm; out_valid=1 for exactly the following cycle.

Optional Feature:
SUB_EN: when defined, opcode A = SUB A,B: A<=A-B mod 2^DATA_W, cflag<=borrow (1 when A<B). When undefined, opcode A is NOP.

Decomposition:
- Package cpu_pkg: opcode localparams OP_ADD_AI … OP_JMP, NOP encoding, INSTR_W/PAGE_W derivation helpers.
- One sub-module, cpu_alu: combinational DATA_W adder/subtractor with carry/borrow out, used by all ADD/SUB ops.

Test Plan:
- Reset low mid-run -> address=0x000, A=B=out_port=0, out_valid=0 at once; release with mem_ready=1 -> address 0x001 after first edge.
- MOV A,3 (0x33); ADD A,0xE (0x0E); JNC 5 (0xE5) -> A=0x1, cflag=1, JNC not taken, address continues sequentially, cflag then 0.
- LDPG 1 (0xC1); LDPG 2 (0xC2); JMP 3 (0xF3); MOV B,7 (0x77) next in memory -> next address 0x123, B stays 0 (squashed).
- mem_ready=0 for 3 cycles after MOV A,5 -> address holds, A=5 after first edge then unchanged, no spurious writes; resumes on mem_ready=1.
- OUT imm 9 (0xB9) -> out_port=9, out_valid high exactly 1 cycle; PC at 0xFFF with mem_ready=1 -> wraps to 0x000.
- SUB_EN defined, A=2, B=3, opcode 0xA0 -> A=0xF, cflag=1; undefined -> A=2, cflag unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined accumulator CPU: opcode encodings and
// width derivation helpers used by the core and its testbench.
package cpu_pkg;

  localparam logic [3:0] OP_ADD_AI = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A   = 4'h2;
  localparam logic [3:0] OP_MOV_AI = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_BI = 4'h5;
  localparam logic [3:0] OP_IN_B   = 4'h6;
  localparam logic [3:0] OP_MOV_BI = 4'h7;
  localparam logic [3:0] OP_ADD_AB = 4'h8;
  localparam logic [3:0] OP_OUT_B  = 4'h9;
  // NOP by default, SUB A,B when the SUB_EN build option is enabled
  localparam logic [3:0] OP_SUB_AB = 4'hA;
  localparam logic [3:0] OP_OUT_I  = 4'hB;
  localparam logic [3:0] OP_LDPG   = 4'hC;
  localparam logic [3:0] OP_NOP    = 4'hD;
  localparam logic [3:0] OP_JNC    = 4'hE;
  localparam logic [3:0] OP_JMP    = 4'hF;

  function automatic int unsigned instr_width(int unsigned data_w);
    return 4 + data_w;
  endfunction

  function automatic int unsigned page_width(int unsigned addr_w, int unsigned data_w);
    return addr_w - data_w;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational DATA_W adder/subtractor. carry is the carry-out on add and
// the borrow (x < y) on subtract.
module cpu_alu #(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] ext;

  // Extend by one bit so the top bit holds carry or borrow
  always_comb begin
    if (sub) ext = {1'b0, x} - {1'b0, y};
    else     ext = {1'b0, x} + {1'b0, y};
    result = ext[DATA_W-1:0];
    carry  = ext[DATA_W];
  end

endmodule

// File: rtl/cpu_core_pipe.sv
// Two-stage (fetch/execute) accumulator CPU core with fetch handshake,
// branch squash, page register for wide jump targets and an output strobe.
// Build option: define SUB_EN to turn opcode A into SUB A,B (else NOP).
module cpu_core_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W+3:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] in_port,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] a_reg_out,
  output logic [DATA_W-1:0] b_reg_out,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid
);

  localparam int unsigned INSTR_W = instr_width(DATA_W);
  localparam int unsigned PAGE_W  = page_width(ADDR_W, DATA_W);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  out_port_q, out_port_d;
  logic               out_valid_q, out_valid_d;
  logic               cflag_q, cflag_d;
  logic [PAGE_W-1:0]  page_q, page_d;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [PAGE_W-1:0] page_ldpg;
  logic              take_jump;

  logic [DATA_W-1:0] alu_x, alu_y, alu_result;
  logic              alu_sub, alu_carry;

  assign opcode = ir_q[INSTR_W-1:DATA_W];
  assign imm    = ir_q[DATA_W-1:0];

  // LDPG shifts the immediate into the bottom of the page register
  if (PAGE_W > DATA_W) begin : g_page_wide
    assign page_ldpg = {page_q[PAGE_W-DATA_W-1:0], imm};
  end else begin : g_page_narrow
    assign page_ldpg = imm[PAGE_W-1:0];
  end

  // Select ALU operands for the executing instruction
  always_comb begin
    alu_x   = a_q;
    alu_y   = imm;
    alu_sub = 1'b0;
    case (opcode)
      OP_ADD_BI: alu_x = b_q;
      OP_ADD_AB: alu_y = b_q;
`ifdef SUB_EN
      OP_SUB_AB: begin
        alu_y   = b_q;
        alu_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .x      (alu_x),
    .y      (alu_y),
    .sub    (alu_sub),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Execute the IR and compute the next fetch; a taken jump wins over fetch
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    out_port_d  = out_port_q;
    out_valid_d = 1'b0;
    cflag_d     = cflag_q;
    page_d      = page_q;
    take_jump   = 1'b0;

    if (ir_valid_q) begin
      case (opcode)
        OP_ADD_AI: begin a_d = alu_result; cflag_d = alu_carry; end
        OP_MOV_AB: begin a_d = b_q;        cflag_d = 1'b0;      end
        OP_IN_A:   begin a_d = in_port;    cflag_d = 1'b0;      end
        OP_MOV_AI: begin a_d = imm;        cflag_d = 1'b0;      end
        OP_MOV_BA: begin b_d = a_q;        cflag_d = 1'b0;      end
        OP_ADD_BI: begin b_d = alu_result; cflag_d = alu_carry; end
        OP_IN_B:   begin b_d = in_port;    cflag_d = 1'b0;      end
        OP_MOV_BI: begin b_d = imm;        cflag_d = 1'b0;      end
        OP_ADD_AB: begin a_d = alu_result; cflag_d = alu_carry; end
        OP_OUT_B: begin
          out_port_d  = b_q;
          out_valid_d = 1'b1;
          cflag_d     = 1'b0;
        end
        OP_SUB_AB: begin
`ifdef SUB_EN
          a_d     = alu_result;
          cflag_d = alu_carry;
`endif
        end
        OP_OUT_I: begin
          out_port_d  = imm;
          out_valid_d = 1'b1;
          cflag_d     = 1'b0;
        end
        OP_LDPG: begin page_d = page_ldpg; cflag_d = 1'b0; end
        OP_JNC: begin
          take_jump = ~cflag_q;
          cflag_d   = 1'b0;
        end
        OP_JMP: begin take_jump = 1'b1; cflag_d = 1'b0; end
        default: ;
      endcase
    end

    ir_d = ir_q;
    if (take_jump) begin
      // The word fetched alongside a taken jump is squashed
      pc_d       = {page_q, imm};
      ir_valid_d = 1'b0;
    end else if (mem_ready) begin
      ir_d       = mem_rdata;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(1);
    end else begin
      pc_d       = pc_q;
      ir_valid_d = 1'b0;
    end
  end

  // Architectural and pipeline state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      ir_q        <= {OP_NOP, {DATA_W{1'b0}}};
      ir_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      cflag_q     <= 1'b0;
      page_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      cflag_q     <= cflag_d;
      page_q      <= page_d;
    end
  end

  assign address   = pc_q;
  assign a_reg_out = a_q;
  assign b_reg_out = b_q;
  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;

endmodule
